// File: rtl/user_obi_arbiter.sv
// Round-robin OBI arbiter: NumMgr user managers share one downstream port, with in-order response routing.
// Define USER_OBI_ARB_FIXED_PRIO_EN to get fixed priority, where the lowest index wins.
module user_obi_arbiter #(
    parameter int unsigned NumMgr         = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumMgr-1:0]             mgr_req_i,
    output logic [NumMgr-1:0]             mgr_gnt_o,
    input  logic [NumMgr*AddrWidth-1:0]   mgr_addr_i,
    input  logic [NumMgr-1:0]             mgr_we_i,
    input  logic [NumMgr*DataWidth/8-1:0] mgr_be_i,
    input  logic [NumMgr*DataWidth-1:0]   mgr_wdata_i,
    output logic [NumMgr-1:0]             mgr_rvalid_o,
    output logic [DataWidth-1:0]          mgr_rdata_o,
    output logic                          mgr_err_o,
    output logic                          obi_req_o,
    input  logic                          obi_gnt_i,
    output logic [AddrWidth-1:0]          obi_addr_o,
    output logic                          obi_we_o,
    output logic [DataWidth/8-1:0]        obi_be_o,
    output logic [DataWidth-1:0]          obi_wdata_o,
    input  logic                          obi_rvalid_i,
    input  logic [DataWidth-1:0]          obi_rdata_i,
    input  logic                          obi_err_i,
    output logic                          protocol_err_o
);

    localparam int unsigned IdxW    = (NumMgr > 1) ? $clog2(NumMgr) : 1;
    localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
    localparam int unsigned BeWidth = DataWidth / 8;

    logic [IdxW-1:0] prio;
    logic [IdxW-1:0] win;
    logic [IdxW-1:0] lock_q;
    logic            lock_vld_q;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] cnt_q;
    logic            protocol_err_q;
    logic            any_req, fifo_full, fifo_empty, hs, pop, stray;
    int unsigned     wsel, hsel;

    assign any_req    = !rst_i && (|mgr_req_i);
    assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
    assign fifo_empty = (cnt_q == '0);
    assign obi_req_o  = any_req && !fifo_full;
    assign hs         = obi_req_o && obi_gnt_i;
    assign pop        = !rst_i && obi_rvalid_i && !fifo_empty;
    assign stray      = obi_rvalid_i && fifo_empty;

    assign protocol_err_o = protocol_err_q;

    // Cyclic search from prio; an unacknowledged winner stays locked so its payload cannot change.
    always_comb begin
        int unsigned idx;
        logic        found;
        win   = prio;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NumMgr; i++) begin
            idx = (32'(prio) + i) % NumMgr;
            if (!found && mgr_req_i[idx]) begin
                win   = IdxW'(idx);
                found = 1'b1;
            end
        end
        if (lock_vld_q) begin
            win = lock_q;
        end
    end

    always_comb begin
        wsel        = 32'(win);
        obi_addr_o  = '0;
        obi_we_o    = 1'b0;
        obi_be_o    = '0;
        obi_wdata_o = '0;
        mgr_gnt_o   = '0;
        if (obi_req_o) begin
            obi_addr_o  = mgr_addr_i[wsel*AddrWidth +: AddrWidth];
            obi_we_o    = mgr_we_i[wsel];
            obi_be_o    = mgr_be_i[wsel*BeWidth +: BeWidth];
            obi_wdata_o = mgr_wdata_i[wsel*DataWidth +: DataWidth];
        end
        if (hs) begin
            mgr_gnt_o[wsel] = 1'b1;
        end
    end

    always_comb begin
        hsel         = 32'(fifo_q[rptr_q]);
        mgr_rvalid_o = '0;
        mgr_rdata_o  = '0;
        mgr_err_o    = 1'b0;
        if (pop) begin
            mgr_rvalid_o[hsel] = 1'b1;
            mgr_rdata_o        = obi_rdata_i;
            mgr_err_o          = obi_err_i;
        end
    end

`ifdef USER_OBI_ARB_FIXED_PRIO_EN
    assign prio = '0;
`else
    logic [IdxW-1:0] prio_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q <= '0;
        end else if (hs) begin
            prio_q <= (win == IdxW'(NumMgr - 1)) ? '0 : win + 1'b1;
        end
    end

    assign prio = prio_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q     <= '0;
            lock_vld_q <= 1'b0;
        end else if (hs) begin
            lock_vld_q <= 1'b0;
        end else if (obi_req_o) begin
            lock_q     <= win;
            lock_vld_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                fifo_q[i] <= '0;
            end
            wptr_q         <= '0;
            rptr_q         <= '0;
            cnt_q          <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            if (hs) begin
                fifo_q[wptr_q] <= win;
                wptr_q <= (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + 1'b1;
            end
            unique case ({hs, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            // A response with nothing outstanding is dropped and flagged until reset.
            if (stray) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/user_obi_arbiter.md
# user_obi_arbiter

Round-robin arbiter sharing the user domain's single OBI manager port into the croc domain crossbar between `NumMgr` user-domain managers (e.g. a DMA engine and an accelerator fetch unit). It forwards one request per cycle downstream and tracks outstanding transactions in an in-order routing FIFO. It returns each response to the manager that issued the matching request. It sits inside `user_domain`, between the user managers and the user manager OBI request/response pair.

## Interface
Parameters:
- `NumMgr`, 2, number of upstream managers (2..8)
- `AddrWidth`, 32, OBI address width
- `DataWidth`, 32, OBI data width
- `MaxOutstanding`, 2, routing FIFO depth (1..8); maximum in-flight downstream transactions

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous, active-high reset
- `mgr_req_i`  in  NumMgr  per-manager request
- `mgr_gnt_o`  out  NumMgr  per-manager grant
- `mgr_addr_i`  in  NumMgr×AddrWidth  per-manager address
- `mgr_we_i`  in  NumMgr  per-manager write enable
- `mgr_be_i`  in  NumMgr×DataWidth/8  per-manager byte enables
- `mgr_wdata_i`  in  NumMgr×DataWidth  per-manager write data
- `mgr_rvalid_o`  out  NumMgr  per-manager response valid
- `mgr_rdata_o`  out  DataWidth  response data, shared by all managers; qualified by `mgr_rvalid_o`
- `mgr_err_o`  out  1  response error, shared; qualified by `mgr_rvalid_o`
- `obi_req_o` / `obi_gnt_i`  out/in  1  downstream request/grant
- `obi_addr_o`, `obi_we_o`, `obi_be_o`, `obi_wdata_o`  out  AddrWidth/1/DataWidth/8/DataWidth  downstream request payload
- `obi_rvalid_i`, `obi_rdata_i`, `obi_err_i`  in  1/DataWidth/1  downstream response
- `protocol_err_o`  out  1  sticky flag: `obi_rvalid_i` arrived with an empty routing FIFO

## Operation
- Arbitration: the winner is the first requesting manager at or after `prio_q`, searched cyclically.
- `obi_req_o` = (any `mgr_req_i`) && !fifo_full. The payload is muxed from the winner; it is 0 when no request is active.
- `mgr_gnt_o[w]` = `obi_gnt_i` && `obi_req_o` for the winner `w`; all other grant bits are 0.
- Lock:
  - If `obi_req_o`=1 and `obi_gnt_i`=0, store the winner index in `lock_q`, set `lock_vld_q`, and keep that winner on following cycles until handshake.
  - This keeps the payload stable, as OBI requires.
  - A lower-index request arriving meanwhile does not preempt it.
- Handshake (`obi_req_o` && `obi_gnt_i`):
  - push the winner index into the FIFO;
  - set `prio_q` = (winner+1) mod NumMgr;
  - clear `lock_vld_q`.
- Response:
  - On `obi_rvalid_i`, pop the FIFO head `h`.
  - Drive `mgr_rvalid_o[h]`=1, with `mgr_rdata_o`=`obi_rdata_i` and `mgr_err_o`=`obi_err_i`.
  - Responses are returned strictly in order.
- FIFO full:
  - `obi_req_o` is held at 0.
  - A pop in the same cycle does not unblock the push; the request is reissued the next cycle.
- FIFO empty with `obi_rvalid_i`: drop the response, set `protocol_err_o`=1 (cleared only by reset), and leave the pointers unchanged.
- Simultaneous push and pop when not full: both happen; the count is unchanged.

## Timing
- Request path is combinational, zero latency: `mgr_req_i` → `obi_req_o`, and `obi_gnt_i` → `mgr_gnt_o`.
- Response path is combinational: `obi_rvalid_i` → `mgr_rvalid_o` in the same cycle.
- State (all updated on `clk_i` rising edge): `prio_q`, `lock_q`, `lock_vld_q`, FIFO storage, read/write pointers, count, `protocol_err_q`.
- Reset values: `prio_q`=0, FIFO empty, `lock_vld_q`=0, `protocol_err_o`=0.
- All outputs are 0 during reset and while no request is present.
- Reset asserted mid-transaction: in-flight routing entries are discarded. Later stray responses are flagged as protocol errors.
- Pointer wrap: pointers wrap modulo `MaxOutstanding`; the count ranges 0..MaxOutstanding.

## Configuration
- `USER_OBI_ARB_FIXED_PRIO_EN` defined:
  - fixed priority, lowest index wins;
  - `prio_q` is not implemented and treated as 0;
  - the lock behaviour is unchanged.
- Not defined: round-robin as described above.

## Test plan
- Single manager 0 read, `obi_gnt_i`=1, `obi_rvalid_i` 1 cycle later with rdata 0xDEADBEEF:
  - `mgr_gnt_o`=2'b01 in the request cycle;
  - next cycle `mgr_rvalid_o`=2'b01 and `mgr_rdata_o`=0xDEADBEEF.
- Both managers request continuously, gnt always 1:
  - grants alternate 01,10,01,10;
  - with `USER_OBI_ARB_FIXED_PRIO_EN` the grant stays 01.
- Manager 1 wins with `obi_gnt_i`=0 for 3 cycles while manager 0 raises its request:
  - `obi_addr_o` stays at manager 1's address for all 3 cycles;
  - manager 1 is granted first, then manager 0.
- `MaxOutstanding`=2, two grants with no responses:
  - `obi_req_o`=0 on the third cycle despite pending requests;
  - after one `obi_rvalid_i`, `obi_req_o`=1 on the following cycle.
- Interleaved requests: manager 0 then manager 1 granted, responses 0x11 then 0x22 with `obi_err_i`=1 on the second:
  - `mgr_rvalid_o`=01 with data 0x11;
  - then `mgr_rvalid_o`=10 with data 0x22 and `mgr_err_o`=1.
- `obi_rvalid_i` pulse after reset with nothing outstanding:
  - `protocol_err_o`=1 from the next cycle;
  - `mgr_rvalid_o`=0;
  - `protocol_err_o` is cleared by asserting `rst_i`.
